i2s_tx_stream: RTL and testbench

- Stereo I2S slave transmitter fed by a valid/ready sample stream; replaces the ad-hoc shift logic in the top level.
- Upstream producer (sine table, USB audio, synth) pushes left/right pairs into a small FIFO.
- The block synchronises the externally mastered i2s_sclk/i2s_lrclk into clk and shifts data MSB-first on i2s_din.
- Reports FIFO level and underruns.

---
 rtl/i2s_tx_stream.sv | 116 +++++++++++
 tb/tb_i2s_tx_stream.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_stream.sv
// Stereo I2S slave transmitter: valid/ready stereo-pair FIFO feeding an MSB-first shifter
// clocked by synchronised strobes of the externally mastered bit clock and word select.
module i2s_tx_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             i2s_sclk,
    input  logic             i2s_lrclk,
    output logic             i2s_din,
    output logic [AW:0]      level,
    output logic             underrun,
    output logic [7:0]       underrun_cnt
);

    localparam int unsigned Depth     = 2 ** AW;
    localparam logic [AW:0] FullLevel = {1'b1, {AW{1'b0}}};

    logic [1:0]           sclk_sync_q;
    logic [1:0]           lrclk_sync_q;
    logic                 sclk_rise_q;
    logic                 sclk_fall_q;
    logic                 ws_q;
    logic [2*WIDTH-1:0]   mem_q [Depth];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW:0]          count_q;
    logic [WIDTH-1:0]     shreg_q;
    logic [WIDTH-1:0]     held_right_q;
    logic                 underrun_q;
    logic [7:0]           underrun_cnt_q;

    logic ws_change;
    logic left_load;
    logic fifo_empty;
    logic push;
    logic pop;

    always_comb begin
        ws_change  = sclk_rise_q & (lrclk_sync_q[1] != ws_q);
        left_load  = ws_change & ~lrclk_sync_q[1];
        fifo_empty = (count_q == '0);
        in_ready   = (count_q != FullLevel);
        push       = in_valid & in_ready;
        // Underrun is only judged at left loads so a pair is never split across frames.
        pop        = left_load & ~fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q    <= '0;
            lrclk_sync_q   <= '0;
            sclk_rise_q    <= 1'b0;
            sclk_fall_q    <= 1'b0;
            ws_q           <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            shreg_q        <= '0;
            held_right_q   <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0], i2s_sclk};
            lrclk_sync_q <= {lrclk_sync_q[0], i2s_lrclk};
            sclk_rise_q  <= sclk_sync_q[0] & ~sclk_sync_q[1];
            sclk_fall_q  <= ~sclk_sync_q[0] & sclk_sync_q[1];
            underrun_q   <= 1'b0;

            if (push) begin
                mem_q[wr_ptr_q] <= {in_left, in_right};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            if (ws_change) begin
                ws_q <= lrclk_sync_q[1];
                if (lrclk_sync_q[1]) begin
                    shreg_q <= held_right_q;
                end else if (!fifo_empty) begin
                    {shreg_q, held_right_q} <= mem_q[rd_ptr_q];
                end else begin
                    shreg_q      <= '0;
                    held_right_q <= '0;
                    underrun_q   <= 1'b1;
                    if (underrun_cnt_q != 8'hFF) begin
                        underrun_cnt_q <= underrun_cnt_q + 1'b1;
                    end
                end
            end else if (sclk_fall_q) begin
                shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign i2s_din      = shreg_q[WIDTH-1];
    assign level        = count_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx_stream.sv
// Directed bench for i2s_tx_stream: drives sclk = clk/8 and checks serial words against a
// small pair-queue model of the FIFO and held-right behaviour.
module tb_i2s_tx_stream;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned AW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  in_left;
    logic [WIDTH-1:0]  in_right;
    logic              in_valid;
    logic              in_ready;
    logic              i2s_sclk;
    logic              i2s_lrclk;
    logic              i2s_din;
    logic [AW:0]       level;
    logic              underrun;
    logic [7:0]        underrun_cnt;

    i2s_tx_stream #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_left      (in_left),
        .in_right     (in_right),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_din      (i2s_din),
        .level        (level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0]  exp_q[$];
    logic         m_ws;
    logic [15:0]  m_held;
    logic [AW:0]  snap_pre, snap_load, first_pre, first_load;
    logic         snap_rdy, first_rdy;

    int   ucycles = 0;
    int   ulong   = 0;
    logic u_prev  = 1'b0;

    // Pulse monitor: counts clk cycles with underrun high and back-to-back highs.
    always @(posedge clk) begin
        if (underrun === 1'b1) begin
            ucycles = ucycles + 1;
            if (u_prev) ulong = ulong + 1;
        end
        u_prev = (underrun === 1'b1);
    end

    task automatic model_reset();
        exp_q.delete();
        m_ws   = 1'b0;
        m_held = '0;
    endtask

    // One sclk period: fall (with lrclk update) then rise; din sampled late in the high phase.
    task automatic bit_clk(input logic lr, input logic push_now, output logic b);
        @(negedge clk);
        i2s_sclk  = 1'b0;
        i2s_lrclk = lr;
        repeat (4) @(posedge clk);
        @(negedge clk);
        i2s_sclk = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        snap_pre = level;
        if (push_now) in_valid = 1'b1;
        @(posedge clk); #1;
        snap_load = level;
        snap_rdy  = in_ready;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        b = i2s_din;
    endtask

    task automatic half(input logic lr, input int nbits, input string name,
                        input logic push_first);
        logic [15:0] w;
        logic [31:0] got;
        logic [31:0] want;
        logic        b;
        w = '0;
        if (lr != m_ws) begin
            if (!lr) begin
                if (exp_q.size() > 0) begin
                    w      = exp_q[0][31:16];
                    m_held = exp_q[0][15:0];
                    void'(exp_q.pop_front());
                end else begin
                    m_held = '0;
                end
            end else begin
                w = m_held;
            end
        end
        m_ws = lr;
        got  = '0;
        want = '0;
        for (int i = 0; i < nbits; i++) begin
            bit_clk(lr, push_first && (i == 0), b);
            if (i == 0) begin
                first_pre  = snap_pre;
                first_load = snap_load;
                first_rdy  = snap_rdy;
            end
            got  = {got[30:0], b};
            want = {want[30:0], (i < 16) ? w[15-i] : 1'b0};
        end
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: din bits got %h want %h", name, got, want);
        end
    endtask

    task automatic frame(input string name);
        half(1'b0, 32, {name, "_left"}, 1'b0);
        half(1'b1, 32, {name, "_right"}, 1'b0);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back({l, r});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        i2s_sclk  = 1'b0;
        i2s_lrclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        i2s_sclk  = 1'b0;
        i2s_lrclk = 1'b0;
        repeat (2) @(negedge clk);
        tests_run += 5;
        if (level !== 3'd0) begin
            tests_failed++; $display("FAIL reset_level: got %0d want 0", level);
        end
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        if (i2s_din !== 1'b0) begin
            tests_failed++; $display("FAIL reset_din: got %b want 0", i2s_din);
        end
        if (underrun !== 1'b0) begin
            tests_failed++; $display("FAIL reset_underrun: got %b want 0", underrun);
        end
        if (underrun_cnt !== 8'd0) begin
            tests_failed++; $display("FAIL reset_underrun_cnt: got %0d want 0", underrun_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        push(16'hA5C3, 16'h0F0F);
        tests_run++;
        if (level !== 3'd1) begin
            tests_failed++; $display("FAIL basic_level1: got %0d want 1", level);
        end
        half(1'b1, 32, "basic_first_right", 1'b0);
        half(1'b0, 32, "basic_left_a5c3", 1'b0);
        tests_run++;
        if (level !== 3'd0) begin
            tests_failed++; $display("FAIL basic_level0: got %0d want 0", level);
        end
        half(1'b1, 32, "basic_right_0f0f", 1'b0);
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) push(16'hC100 + 16'(k), 16'h3200 + 16'(k));
        tests_run += 2;
        if (level !== 3'd4) begin
            tests_failed++; $display("FAIL full_level4: got %0d want 4", level);
        end
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL full_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        in_left  = 16'hDEAD;
        in_right = 16'hBEEF;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        tests_run++;
        if (level !== 3'd4) begin
            tests_failed++; $display("FAIL full_fifth_ignored: level %0d want 4", level);
        end
        half(1'b0, 32, "full_left0", 1'b0);
        tests_run += 3;
        if (first_pre !== 3'd4) begin
            tests_failed++; $display("FAIL full_pre_pop: level %0d want 4", first_pre);
        end
        if (first_load !== 3'd3) begin
            tests_failed++; $display("FAIL full_pop_level: level %0d want 3", first_load);
        end
        if (first_rdy !== 1'b1) begin
            tests_failed++; $display("FAIL full_pop_ready: got %b want 1", first_rdy);
        end
        half(1'b1, 32, "full_right0", 1'b0);
        for (int k = 1; k < 4; k++) frame("full_drain");
        tests_run++;
        if (level !== 3'd0) begin
            tests_failed++; $display("FAIL full_drained: level %0d want 0", level);
        end
    endtask

    task automatic test_back_to_back();
        int nxt;
        push(16'h5A00, 16'h6B00);
        push(16'h5A01, 16'h6B01);
        in_left  = 16'h5A02;
        in_right = 16'h6B02;
        half(1'b0, 32, "same_cycle_left", 1'b1);
        exp_q.push_back({16'h5A02, 16'h6B02});
        tests_run += 2;
        if (first_pre !== 3'd2) begin
            tests_failed++; $display("FAIL same_cycle_pre: level %0d want 2", first_pre);
        end
        if (first_load !== 3'd2) begin
            tests_failed++; $display("FAIL same_cycle_level: level %0d want 2", first_load);
        end
        half(1'b1, 32, "same_cycle_right", 1'b0);
        nxt = 0;
        while (nxt < 10 || exp_q.size() > 0) begin
            while (exp_q.size() < 4 && nxt < 10) begin
                push(16'h7000 + 16'(nxt), 16'h8000 + 16'(nxt));
                nxt++;
            end
            frame("wrap_order");
        end
    endtask

    task automatic test_underrun();
        int base;
        apply_reset();
        half(1'b1, 32, "ur_first_right", 1'b0);
        base = ucycles;
        u_prev = 1'b0;
        ulong  = 0;
        for (int k = 0; k < 3; k++) frame("ur_frame");
        tests_run += 3;
        if (ucycles - base !== 3) begin
            tests_failed++; $display("FAIL ur_pulses: got %0d want 3", ucycles - base);
        end
        if (ulong !== 0) begin
            tests_failed++; $display("FAIL ur_pulse_width: long %0d want 0", ulong);
        end
        if (underrun_cnt !== 8'd3) begin
            tests_failed++; $display("FAIL ur_cnt3: got %0d want 3", underrun_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 249; k++) begin
            half(1'b0, 2, "sat_left", 1'b0);
            half(1'b1, 2, "sat_right", 1'b0);
        end
        tests_run++;
        if (underrun_cnt !== 8'd252) begin
            tests_failed++; $display("FAIL sat_cnt252: got %0d want 252", underrun_cnt);
        end
        for (int k = 0; k < 48; k++) begin
            half(1'b0, 2, "sat_left", 1'b0);
            half(1'b1, 2, "sat_right", 1'b0);
        end
        tests_run++;
        if (underrun_cnt !== 8'd255) begin
            tests_failed++; $display("FAIL sat_cnt255: got %0d want 255", underrun_cnt);
        end
    endtask

    task automatic test_reset_mid();
        push(16'h1234, 16'hFFFF);
        push(16'h4321, 16'h1111);
        half(1'b0, 32, "mid_left", 1'b0);
        half(1'b1, 5, "mid_right_part", 1'b0);
        #2 rst = 1'b1;
        #1;
        tests_run += 5;
        if (i2s_din !== 1'b0) begin
            tests_failed++; $display("FAIL mid_rst_din: got %b want 0", i2s_din);
        end
        if (level !== 3'd0) begin
            tests_failed++; $display("FAIL mid_rst_level: got %0d want 0", level);
        end
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL mid_rst_ready: got %b want 1", in_ready);
        end
        if (underrun !== 1'b0) begin
            tests_failed++; $display("FAIL mid_rst_underrun: got %b want 0", underrun);
        end
        if (underrun_cnt !== 8'd0) begin
            tests_failed++; $display("FAIL mid_rst_cnt: got %0d want 0", underrun_cnt);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        half(1'b1, 27, "mid_after_right", 1'b0);
        push(16'hABCD, 16'h5678);
        frame("mid_new_pair");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_underrun();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
